window_streamer: RTL
====================

// Module: window_streamer
// PURPOSE
//  Producer side of the 72-bit 3x3 window interface consumed by the convolution stage.
//  - Accepts a raster-order grayscale pixel stream, one pixel per handshake.
//  - Buffers two image lines.
//  - Emits every fully-interior 3x3 neighbourhood as a packed 72-bit word.
//  - Has valid/ready backpressure on both sides.
//  - Sits between the image loader and the Gaussian/Sobel convolution blocks.
// PARAMETERS
//  COLDepth      8    bits per pixel; window width is 9*COLDepth
//  Image_width   16   pixels per line, >=3
//  Image_height  16   lines per frame, >=3
//  X_W           $clog2(Image_width)   column/x coordinate width (derived)
//  Y_W           $clog2(Image_height)  row/y coordinate width (derived)
// PORTS
//  clk           in   1            rising-edge clock
//  reset         in   1            synchronous, active-high
//  start         in   1            1-cycle pulse; begins a frame when IDLE
//  pix_in        in   COLDepth     raster pixel, x fastest
//  pix_valid     in   1            pix_in valid
//  pix_ready     out  1            block accepts pix_in this cycle
//  window_out    out  9*COLDepth   packed 3x3 window
//  window_valid  out  1            window_out/window_x/window_y valid
//  window_ready  in   1            consumer takes window this cycle
//  window_x      out  X_W          window centre column
//  window_y      out  Y_W          window centre row
//  busy          out  1            high in RUN or DRAIN
//  frame_done    out  1            1-cycle pulse, last window taken
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters and window regs 0; line-buffer contents are don't-care.
//  FSM:
//   IDLE  -> RUN on start.
//   RUN   -> DRAIN when the pixel at (W-1,H-1) is accepted.
//   DRAIN -> DONE when the last window is accepted.
//   DONE  -> IDLE after 1 cycle; frame_done=1 in DONE only.
//  start outside IDLE is ignored.
//  Accept: a pixel is taken when pix_valid && pix_ready.
//  pix_ready = (state==RUN) && !(window_valid && !window_ready).
//  Counters col/row track the accepted pixel:
//   - col wraps W-1 -> 0 and increments row.
//   - Both counters clear on entering RUN.
//  Line buffers: two W-deep pixel RAMs/regs hold rows r-1 and r-2, written at index col on each accept.
//  Window regs: 3x3 shift array; each accept shifts left one column and loads {lb2[col], lb1[col], pix_in} as the new right column.
//  Packing is row-major, top-left in the MSBs:
//   - [71:64]=(x-1,y-1), [63:56]=(x,y-1), [55:48]=(x+1,y-1)
//   - [47:40]=(x-1,y), [39:32]=(x,y), [31:24]=(x+1,y)
//   - [23:16]=(x-1,y+1), [15:8]=(x,y+1), [7:0]=(x+1,y+1)
//   - Generalises to COLDepth slices.
//  Emission:
//   - Accepting pixel (col,row) with col>=2 && row>=2 sets window_valid=1 on the next cycle.
//   - Window centre: window_x=col-1, window_y=row-1. Latency is 1 cycle from accept.
//   - Exactly (W-2)*(H-2) windows per frame; border pixels produce no windows.
//   - An accept with col<2 or row<2 clears window_valid if the current window was taken.
//  Hold: while window_valid && !window_ready, window_out/x/y are stable and no pixel is accepted.
//  Simultaneous: a window is taken and a new pixel accepted in the same cycle -> the next window (if any) appears next cycle. Steady-state throughput is 1 window/cycle.
//  Line wrap: the window regs hold stale columns after col wraps. They are not emitted until col>=2 refills them.
//  DRAIN: pix_ready=0; window_valid stays until taken, then DONE.
//  Reset mid-frame: returns to IDLE on the next edge; any pending window is dropped; no frame_done.
//  Arithmetic: counters saturate-free, modulo their widths; no pixel arithmetic in this block.
// TESTING
//  Common setup for tests 1-4: W=5, H=4, pix=y*5+x, window_ready=1.
//  1 Basic frame: start, stream 20 pixels back-to-back.
//    - First window is 1 cycle after pixel 12 is accepted.
//    - window_out=72'h00_01_02_05_06_07_0A_0B_0C, x=1, y=1.
//    - 6 windows total; frame_done pulses once.
//  2 Line wrap: same frame.
//    - 4th window is x=1, y=2, window_out=72'h05_06_07_0A_0B_0C_0F_10_11.
//    - No window is emitted for col 0/1 pixels.
//  3 Backpressure: drop window_ready for 3 cycles at the 2nd window.
//    - window_out holds 72'h01_02_03_06_07_08_0B_0C_0D.
//    - pix_ready=0 for the stall; no data is lost; 6 windows total.
//  4 Input bubbles: pix_valid toggles 1/0.
//    - Window sequence and values match test 1; frame_done only after the 6th window is taken.
//  5 Start/reset: start pulsed during RUN -> ignored.
//    - reset asserted after 10 pixels -> next cycle all outputs 0, state IDLE.
//    - A new start and full frame then gives the test-1 results.
//  6 Default 16x16 random frame: 196 windows.
//    - Each window matches a reference model.
//    - Coordinates run x=1..14, y=1..14 in order.

Source files
------------

// File: rtl/window_streamer.sv
// Streams raster pixels through two line buffers and emits interior 3x3 windows, 1 cycle after the pixel is accepted.
// A pending window that has not been taken stalls pix_ready; a window is taken and a new pixel is accepted in the same cycle.
module window_streamer #(
  parameter int COLDepth     = 8,
  parameter int Image_width  = 16,
  parameter int Image_height = 16,
  parameter int X_W          = $clog2(Image_width),
  parameter int Y_W          = $clog2(Image_height)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COLDepth-1:0]   pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [9*COLDepth-1:0] window_out,
  output logic                  window_valid,
  input  logic                  window_ready,
  output logic [X_W-1:0]        window_x,
  output logic [Y_W-1:0]        window_y,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [X_W-1:0] COL_LAST = X_W'(Image_width - 1);
  localparam logic [Y_W-1:0] ROW_LAST = Y_W'(Image_height - 1);

  logic [1:0]          state;
  logic [X_W-1:0]      col;
  logic [Y_W-1:0]      row;
  logic [COLDepth-1:0] lb1 [Image_width];
  logic [COLDepth-1:0] lb2 [Image_width];
  logic [COLDepth-1:0] win [3][3];
  logic                accept;
  logic                last_pix;
  logic                interior;
  logic                taken;

  assign pix_ready  = (state == RUN) && !(window_valid && !window_ready);
  assign accept     = pix_valid && pix_ready;
  assign taken      = window_valid && window_ready;
  assign last_pix   = (col == COL_LAST) && (row == ROW_LAST);
  assign interior   = (col >= X_W'(2)) && (row >= Y_W'(2));
  assign busy       = (state == RUN) || (state == DRAIN);
  assign frame_done = (state == DONE);

  // Row-major packing, top-left neighbour in the most significant slice.
  always_comb begin
    window_out = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window_out[(8 - (r * 3 + c)) * COLDepth +: COLDepth] = win[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      window_x     <= '0;
      window_y     <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN:     if (accept && last_pix) state <= DRAIN;
        DRAIN:   if (taken) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2[col];
        win[1][2] <= lb1[col];
        win[2][2] <= pix_in;
      end

      // An accept implies any pending window is being taken this cycle.
      if (accept && interior) begin
        window_valid <= 1'b1;
        window_x     <= col - 1'b1;
        window_y     <= row - 1'b1;
      end else if (taken) begin
        window_valid <= 1'b0;
      end
    end
  end

  // Line buffer contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix_in;
    end
  end

endmodule
